// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, taken-branch and
// LSU-wait hazards, with an LSU timeout that halts the pipe and saturating event counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_adi,
  input  logic [4:0]       id_rs2_adi,
  input  logic             id_rs1_usei,
  input  logic             id_rs2_usei,
  input  logic [4:0]       ex_rd_adi,
  input  logic             ex_rd_wreni,
  input  logic             ex_is_ldi,
  input  logic             ex_br_takeni,
  input  logic             mem_reqi,
  input  logic             mem_acki,
  output logic             pc_eno,
  output logic             if_id_eno,
  output logic             id_ex_eno,
  output logic             ex_mem_eno,
  output logic             if_id_flusho,
  output logic             id_ex_flusho,
  output logic             mem_wb_flusho,
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic memstall, loaduse, active, stall_evt, flush_evt;

  assign memstall = mem_reqi & ~mem_acki;
  assign loaduse  = ex_is_ldi & ex_rd_wreni & (ex_rd_adi != 5'd0) &
                    ((id_rs1_usei & (id_rs1_adi == ex_rd_adi)) |
                     (id_rs2_usei & (id_rs2_adi == ex_rd_adi)));
  assign active   = (state_q == ST_RUN) || (state_q == ST_MEMWAIT);

  // NOTE: every output gets a default first so no path through the if-chain infers a latch.
  always_comb begin
    pc_eno        = 1'b0;
    if_id_eno     = 1'b0;
    id_ex_eno     = 1'b0;
    ex_mem_eno    = 1'b0;
    if_id_flusho  = 1'b1;
    id_ex_flusho  = 1'b1;
    mem_wb_flusho = 1'b1;
    if (active) begin
      if (memstall) begin
        // Whole front of the pipe frozen; a pending branch/load-use is re-seen after release.
        if_id_flusho  = 1'b0;
        id_ex_flusho  = 1'b0;
      end else if (ex_br_takeni) begin
        {pc_eno, if_id_eno, id_ex_eno, ex_mem_eno} = 4'b1111;
        mem_wb_flusho = 1'b0;
      end else if (loaduse) begin
        id_ex_eno     = 1'b1;
        ex_mem_eno    = 1'b1;
        if_id_flusho  = 1'b0;
        mem_wb_flusho = 1'b0;
      end else begin
        {pc_eno, if_id_eno, id_ex_eno, ex_mem_eno} = 4'b1111;
        {if_id_flusho, id_ex_flusho, mem_wb_flusho} = 3'b000;
      end
    end
  end

  assign stall_evt = active & ~pc_eno;
  assign flush_evt = active & ~memstall & ex_br_takeni;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN, ST_MEMWAIT: begin
        if (memstall) begin
          // The timeout wins over the normal RUN/MEMWAIT transition.
          if (wcnt_q + WCNT_W'(1) == WCNT_W'(MEM_TIMEOUT)) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            wcnt_d  = wcnt_q + WCNT_W'(1);
            state_d = ST_MEMWAIT;
          end
        end else begin
          wcnt_d  = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_HALT;
    endcase
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It watches register usage in ID, the instruction in EX, the redirect from EX and the LSU handshake in MEM. From these it drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers; `mem_wb_flusho` feeds the MEM/WB flush select. It also runs an LSU-wait timeout that halts the pipeline, and keeps saturating stall and flush event counters.

## Interface
- `MEM_TIMEOUT`, default 16: consecutive LSU-stall cycles that trigger HALT; legal range ≥2.
- `CNT_W`, default 32: width of the event counters.

- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `id_rs1_adi`, `id_rs2_adi`  in  5 each  source registers of the instruction in ID.
- `id_rs1_usei`, `id_rs2_usei`  in  1 each  the ID instruction actually reads rs1 / rs2.
- `ex_rd_adi`  in  5  destination register of the instruction in EX.
- `ex_rd_wreni`  in  1  the EX instruction writes rd.
- `ex_is_ldi`  in  1  the EX instruction is a load.
- `ex_br_takeni`  in  1  taken branch/jump resolved in EX.
- `mem_reqi`  in  1  the MEM-stage instruction accesses the LSU.
- `mem_acki`  in  1  LSU completes the access this cycle.
- `pc_eno`, `if_id_eno`, `id_ex_eno`, `ex_mem_eno`  out  1 each  register update enables.
- `if_id_flusho`, `id_ex_flusho`, `mem_wb_flusho`  out  1 each  bubble insert; a flush overrides the enable of the same register.
- `state_o`  out  2  encoding: INIT=0, RUN=1, MEMWAIT=2, HALT=3.
- `err_o`  out  1  sticky LSU timeout flag.
- `stall_cnt_o`, `flush_cnt_o`  out  CNT_W each  saturating event counters.

## Operation
- Conditions, all evaluated combinationally every cycle:
  - memstall = `mem_reqi` & !`mem_acki`.
  - loaduse = `ex_is_ldi` & `ex_rd_wreni` & (`ex_rd_adi`≠0) & ((`id_rs1_usei` & `id_rs1_adi`==`ex_rd_adi`) | (`id_rs2_usei` & `id_rs2_adi`==`ex_rd_adi`)).
- Action in RUN/MEMWAIT, by priority:
  1. memstall: `pc_eno`, `if_id_eno`, `id_ex_eno`, `ex_mem_eno` = 0; `mem_wb_flusho`=1; the other flushes 0. A pending branch or load-use is held frozen and re-evaluated after release.
  2. `ex_br_takeni`: all enables 1; `if_id_flusho`=`id_ex_flusho`=1. This also covers a simultaneous load-use, because the dependent instruction is flushed.
  3. loaduse: `pc_eno`=`if_id_eno`=0; `id_ex_flusho`=1; `ex_mem_eno`=1. Lasts one cycle only: the next cycle the load is in MEM and the hazard clears.
  4. None of the above: all enables 1, all flushes 0.
- INIT and HALT: all enables 0, all flushes 1.
- FSM, next-state on the clock edge:
  - INIT → RUN unconditionally.
  - RUN: memstall → MEMWAIT; otherwise RUN.
  - MEMWAIT: !memstall → RUN; otherwise stay MEMWAIT.
  - HALT: held until reset.
- Wait counter `wcnt` (width clog2(MEM_TIMEOUT+1)):
  - Each memstall edge: if `wcnt`+1 == MEM_TIMEOUT, go to HALT; otherwise `wcnt`++.
  - Any non-memstall edge clears `wcnt`.
  - The timeout overrides the RUN/MEMWAIT next state.
- `err_o` is set on entry to HALT and cleared only by reset.
- `stall_cnt_o` increments on each edge in RUN/MEMWAIT where `pc_eno`==0 (memstall or loaduse).
- `flush_cnt_o` increments on each edge where rule 2 fires.
- Both counters saturate at all-ones.
- `mem_acki` without `mem_reqi` is ignored.

## Timing
- Reset values (asynchronous): state INIT, `wcnt`=0, `err_o`=0, both counters 0.
  - Therefore `state_o`=0, all enables 0, all flushes 1.
- First edge after `rst_ni` rises: RUN. Normal flow starts in the following cycle.
- All enable/flush outputs are combinational from state and inputs: zero-cycle response. `mem_acki` releases the pipeline in the same cycle, so MEM/WB captures the load data on that edge.
- Counters and `err_o` are registered and visible one cycle after the event.
- Release timing:
  - Load-use stall: exactly 1 cycle.
  - LSU stall of N cycles (N < MEM_TIMEOUT): N bubbles into MEM/WB.
  - MEM_TIMEOUT consecutive stall cycles: HALT from the next cycle.
- Reset asserted mid-stall or in HALT: immediate return to INIT values.

## Test plan
- Reset, then idle (no hazards):
  - INIT for 1 cycle: enables 0, flushes 1.
  - Then RUN: all enables 1, flushes 0, counters stay 0.
- Load-use: `ex_is_ldi`=1, `ex_rd_wreni`=1, `ex_rd_adi`=5, `id_rs2_adi`=5, `id_rs2_usei`=1 for one cycle.
  - `pc_eno`=`if_id_eno`=0 and `id_ex_flusho`=1 for 1 cycle; `stall_cnt_o`=1.
  - Repeat with `ex_rd_adi`=0, or with `id_rs2_usei`=0: no stall.
- Branch + load-use in the same cycle: `if_id_flusho`=`id_ex_flusho`=1, `pc_eno`=1, `flush_cnt_o`=1, `stall_cnt_o` unchanged.
- LSU wait: `mem_reqi`=1 with `mem_acki`=0 for 3 cycles, then 1.
  - `state_o` sequence 1,2,2,2,1.
  - `mem_wb_flusho`=1 for 3 cycles; enables 0 for 3 cycles; `stall_cnt_o`=3.
  - Branch held during the wait: flush fires on the ack cycle.
- Timeout with MEM_TIMEOUT=4: `mem_reqi`=1, `mem_acki`=0 held.
  - HALT (`state_o`=3) on the 5th cycle; `err_o`=1.
  - A later `mem_acki`=1 has no effect; only `rst_ni` low clears.
- Counter saturation with CNT_W=4: 20 load-use cycles → `stall_cnt_o`=15 and holds.
